// File: rtl/vram_dma.sv
// CPU-to-VRAM byte copy engine: register-programmed, single-outstanding memory reads,
// VRAM writes held until the video timing opens the writable window.
module vram_dma #(
    parameter int unsigned VRAM_ADDR_WIDTH = 12,
    parameter int unsigned SRC_ADDR_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [2:0]                 cfg_addr_i,
    input  logic [7:0]                 cfg_wdata_i,
    input  logic                       cfg_we_i,
    output logic [SRC_ADDR_WIDTH-1:0]  mem_addr_o,
    output logic                       mem_req_o,
    input  logic [7:0]                 mem_data_i,
    input  logic                       mem_valid_i,
    input  logic                       writable_i,
    output logic [7:0]                 data_out_o,
    output logic [VRAM_ADDR_WIDTH-1:0] address_o,
    output logic                       write_enable_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StWrite} state_e;

    state_e                     st_q, st_d;
    logic [15:0]                src_cfg_q, src_cfg_d;
    logic [11:0]                dst_cfg_q, dst_cfg_d;
    logic [11:0]                len_cfg_q, len_cfg_d;
    logic [SRC_ADDR_WIDTH-1:0]  src_q, src_d;
    logic [VRAM_ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [12:0]                cnt_q, cnt_d;
    logic [7:0]                 data_q, data_d;
    logic                       done_q, done_d;

    logic cmd_we, start, abort;

    assign cmd_we = cfg_we_i && (cfg_addr_i == 3'd6);
    // Abort takes priority over a start carried in the same command byte.
    assign abort  = cmd_we && cfg_wdata_i[1];
    assign start  = cmd_we && cfg_wdata_i[0] && !cfg_wdata_i[1];

    always_comb begin
        src_cfg_d = src_cfg_q;
        dst_cfg_d = dst_cfg_q;
        len_cfg_d = len_cfg_q;
        if (cfg_we_i) begin
            unique case (cfg_addr_i)
                3'd0:    src_cfg_d[7:0]  = cfg_wdata_i;
                3'd1:    src_cfg_d[15:8] = cfg_wdata_i;
                3'd2:    dst_cfg_d[7:0]  = cfg_wdata_i;
                3'd3:    dst_cfg_d[11:8] = cfg_wdata_i[3:0];
                3'd4:    len_cfg_d[7:0]  = cfg_wdata_i;
                3'd5:    len_cfg_d[11:8] = cfg_wdata_i[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        st_d   = st_q;
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        done_d = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    src_d = SRC_ADDR_WIDTH'(src_cfg_q);
                    dst_d = VRAM_ADDR_WIDTH'(dst_cfg_q);
                    cnt_d = (len_cfg_q == 12'd0) ? 13'd4096 : {1'b0, len_cfg_q};
                    st_d  = StFetch;
                end
            end
            StFetch: st_d = StWait;
            StWait: begin
                if (mem_valid_i) begin
                    data_d = mem_data_i;
                    st_d   = StWrite;
                end
            end
            StWrite: begin
                if (writable_i) begin
                    src_d = src_q + SRC_ADDR_WIDTH'(1);
                    dst_d = dst_q + VRAM_ADDR_WIDTH'(1);
                    cnt_d = cnt_q - 13'd1;
                    if (cnt_q == 13'd1) begin
                        st_d   = StIdle;
                        done_d = 1'b1;
                    end else begin
                        st_d = StFetch;
                    end
                end
            end
            default: st_d = StIdle;
        endcase
        if (abort) begin
            st_d   = StIdle;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= StIdle;
            src_cfg_q <= '0;
            dst_cfg_q <= '0;
            len_cfg_q <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            src_cfg_q <= src_cfg_d;
            dst_cfg_q <= dst_cfg_d;
            len_cfg_q <= len_cfg_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign mem_addr_o     = src_q;
    assign mem_req_o      = (st_q == StFetch);
    assign data_out_o     = data_q;
    assign address_o      = dst_q;
    assign write_enable_o = (st_q == StWrite);
    assign busy_o         = (st_q != StIdle);
    assign done_o         = done_q;

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: behavioural memory responder plus a VRAM commit logger.
module tb_vram_dma;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [2:0]  cfg_addr_i = '0;
    logic [7:0]  cfg_wdata_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [15:0] mem_addr_o;
    logic        mem_req_o;
    logic [7:0]  mem_data_i = '0;
    logic        mem_valid_i = 1'b0;
    logic        writable_i = 1'b1;
    logic [7:0]  data_out_o;
    logic [11:0] address_o;
    logic        write_enable_o;
    logic        busy_o;
    logic        done_o;

    int passed = 0;
    int total  = 0;

    vram_dma #(.VRAM_ADDR_WIDTH(12), .SRC_ADDR_WIDTH(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .cfg_we_i       (cfg_we_i),
        .mem_addr_o     (mem_addr_o),
        .mem_req_o      (mem_req_o),
        .mem_data_i     (mem_data_i),
        .mem_valid_i    (mem_valid_i),
        .writable_i     (writable_i),
        .data_out_o     (data_out_o),
        .address_o      (address_o),
        .write_enable_o (write_enable_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #40 clk_i = ~clk_i;

    // Memory model: returns the low address byte `lat` cycles after the request.
    int          lat = 1;
    bit          var_lat = 1'b0;
    int          req_n = 0;
    bit          pend = 1'b0;
    int          left = 0;
    logic [15:0] raddr = '0;
    logic [11:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [15:0] ra_q[$];
    int          done_cnt = 0;

    always @(negedge clk_i) begin
        mem_valid_i = 1'b0;
        if (!rst_ni) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                left--;
                if (left == 0) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = raddr[7:0];
                    pend        = 1'b0;
                end
            end
            if (mem_req_o) begin
                pend  = 1'b1;
                left  = var_lat ? 1 + (req_n % 5) : lat;
                req_n++;
                raddr = mem_addr_o;
                ra_q.push_back(mem_addr_o);
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni && write_enable_o && writable_i) begin
            wa_q.push_back(address_o);
            wd_q.push_back(data_out_o);
        end
        if (done_o) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg(input logic [2:0] a, input logic [7:0] d);
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        cfg_we_i    = 1'b1;
        tick(1);
        cfg_we_i    = 1'b0;
    endtask

    task automatic program_regs(input logic [15:0] src, input logic [11:0] dst,
                                input logic [11:0] len);
        cfg(3'd0, src[7:0]);
        cfg(3'd1, src[15:8]);
        cfg(3'd2, dst[7:0]);
        cfg(3'd3, {4'hA, dst[11:8]});
        cfg(3'd4, len[7:0]);
        cfg(3'd5, {4'h5, len[11:8]});
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        done_cnt = 0;
    endtask

    bit busy_dropped;

    task automatic wait_done(input int max);
        int n;
        n = 0;
        busy_dropped = 1'b0;
        while (!done_o && n < max) begin
            tick(1);
            if (!done_o && !busy_o) busy_dropped = 1'b1;
            n++;
        end
        check("done_within_budget", done_o, 1);
    endtask

    initial begin
        bit held;
        int n;

        #1;
        check("rst_busy", busy_o, 0);
        check("rst_we", write_enable_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_outs", {mem_addr_o, address_o, data_out_o}, 0);
        tick(2);
        check("rst_done", done_o, 0);
        rst_ni = 1'b1;
        tick(1);

        // Basic 4-byte copy and exact done latency.
        program_regs(16'h1234, 12'h800, 12'd4);
        clear_logs();
        cfg(3'd6, 8'h01);
        check("start_busy", busy_o, 1);
        check("start_req", {mem_req_o, mem_addr_o}, {1'b1, 16'h1234});
        tick(2);
        check("first_write", {write_enable_o, address_o, data_out_o}, {1'b1, 12'h800, 8'h34});
        tick(9);
        check("done_not_early", {done_o, busy_o}, 2'b01);
        tick(1);
        check("done_at_12", {done_o, busy_o}, 2'b10);
        tick(1);
        check("done_one_cycle", done_o, 0);
        check("t1_count", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", wa_q[i], 12'h800 + i);
            check("t1_data", wd_q[i], 8'h34 + i);
        end
        check("t1_done_cnt", done_cnt, 1);

        // Writable window closed during the second WRITE.
        clear_logs();
        cfg(3'd6, 8'h01);
        tick(5);
        writable_i = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(write_enable_o && address_o == 12'h801 && data_out_o == 8'h35)) held = 1'b0;
            tick(1);
        end
        writable_i = 1'b1;
        check("stall_hold", held, 1);
        wait_done(100);
        tick(1);
        check("t2_count", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_addr", wa_q[i], 12'h800 + i);
            check("t2_data", wd_q[i], 8'h34 + i);
        end

        // Address wrap on both sides.
        program_regs(16'hFFFF, 12'hFFE, 12'd3);
        clear_logs();
        cfg(3'd6, 8'h01);
        wait_done(100);
        tick(1);
        check("wrap_count", wa_q.size(), 3);
        check("wrap_a0", wa_q[0], 12'hFFE);
        check("wrap_a1", wa_q[1], 12'hFFF);
        check("wrap_a2", wa_q[2], 12'h000);
        check("wrap_d2", wd_q[2], 8'h01);
        check("wrap_r0", ra_q[0], 16'hFFFF);
        check("wrap_r1", ra_q[1], 16'h0000);
        check("wrap_r2", ra_q[2], 16'h0001);

        // LEN=0 copies 4096 bytes.
        program_regs(16'h0000, 12'h123, 12'd0);
        clear_logs();
        cfg(3'd6, 8'h01);
        wait_done(13000);
        tick(2);
        check("len0_count", wa_q.size(), 4096);
        check("len0_first", wa_q[0], 12'h123);
        check("len0_last_a", wa_q[4095], 12'h122);
        check("len0_last_d", wd_q[4095], 8'hFF);
        check("len0_busy", busy_dropped, 0);
        check("len0_done_cnt", done_cnt, 1);

        // Abort in WAIT; the late mem_valid must be ignored.
        lat = 3;
        program_regs(16'h0010, 12'h010, 12'd2);
        clear_logs();
        cfg(3'd6, 8'h01);
        tick(1);
        check("abort_in_wait", {busy_o, mem_req_o, write_enable_o}, 3'b100);
        cfg(3'd6, 8'h02);
        check("abort_busy", busy_o, 0);
        tick(4);
        check("abort_no_write", wa_q.size(), 0);
        check("abort_no_done", done_cnt, 0);
        check("abort_data_kept", data_out_o, 8'hFF);
        check("abort_idle", busy_o, 0);

        lat = 1;
        program_regs(16'h2040, 12'h300, 12'd2);
        clear_logs();
        cfg(3'd6, 8'h01);
        wait_done(50);
        tick(1);
        check("restart_count", wa_q.size(), 2);
        check("restart_a0", wa_q[0], 12'h300);
        check("restart_d0", wd_q[0], 8'h40);
        check("restart_a1", wa_q[1], 12'h301);
        check("restart_d1", wd_q[1], 8'h41);

        cfg(3'd6, 8'h03);
        check("start_abort_same", {busy_o, mem_req_o}, 2'b00);

        // Second START and reconfiguration while busy, variable latency.
        var_lat = 1'b1;
        program_regs(16'h5500, 12'h0A0, 12'd5);
        clear_logs();
        cfg(3'd6, 8'h01);
        tick(3);
        cfg(3'd0, 8'h00);
        cfg(3'd1, 8'h66);
        cfg(3'd6, 8'h01);
        wait_done(200);
        tick(1);
        check("busy_start_count", wa_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("busy_start_addr", wa_q[i], 12'h0A0 + i);
            check("busy_start_data", wd_q[i], i);
            check("busy_start_src", ra_q[i], 16'h5500 + i);
        end
        check("busy_start_done", done_cnt, 1);
        tick(3);
        check("busy_start_idle", busy_o, 0);
        var_lat = 1'b0;

        // Reset asserted mid-WRITE clears outputs asynchronously.
        cfg(3'd6, 8'h01);
        n = 0;
        while (!write_enable_o && n < 20) begin
            tick(1);
            n++;
        end
        check("reach_write", write_enable_o, 1);
        rst_ni = 1'b0;
        #1;
        check("async_rst_we", write_enable_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_outs", {mem_addr_o, address_o, data_out_o}, 0);
        tick(2);
        check("rst_hold_done", done_o, 0);
        rst_ni = 1'b1;
        tick(1);
        cfg(3'd6, 8'h01);
        check("cfg_cleared", {busy_o, mem_req_o, mem_addr_o, address_o}, {2'b11, 16'h0, 12'h0});
        cfg(3'd6, 8'h02);
        check("final_idle", busy_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
